// File: rtl/uart_tx_rr_sched_if.sv
// rtl/uart_tx_rr_sched_if.sv - requester and uart_tx side signals of the round-robin TX scheduler
interface uart_tx_rr_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_active;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic                    err_timeout;

  // Scheduler side
  modport slave (
    input  req_valid, req_data, tx_active,
    output req_ready, tx_start, tx_data, grant_id, busy, err_timeout
  );

  // Requesters plus uart_tx side
  modport master (
    output req_valid, req_data, tx_active,
    input  req_ready, tx_start, tx_data, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_rr_sched.sv
// rtl/uart_tx_rr_sched.sv - round-robin scheduler sharing one uart_tx among byte requesters
module uart_tx_rr_sched #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_rr_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel;
  logic              sel_found;
  logic              accept;
  logic              ack_timeout;
  logic [CNT_W-1:0]  ack_cnt;
  logic [DATA_W-1:0] tx_data_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              err_q;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Pick the first valid requester at or after the round-robin pointer (scan backwards so the nearest wins).
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_idx(rr_ptr, k)]) begin
        sel       = wrap_idx(rr_ptr, k);
        sel_found = 1'b1;
      end
    end
  end

  // A grant needs an idle scheduler and an idle uart_tx; reset blocks any accept pulse.
  assign accept      = rst_n && (state == IDLE) && !bus.tx_active && sel_found;
  assign ack_timeout = (state == WAIT_HI) && !bus.tx_active && (ack_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one byte per pass, wait for the uart_tx frame to start and finish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_active)    state_nxt = WAIT_LO;
        else if (ack_timeout) state_nxt = IDLE;
      end
      WAIT_LO: if (!bus.tx_active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: accept pulse in IDLE, start pulse in LAUNCH.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[sel] = 1'b1;
    bus.tx_start = (state == LAUNCH);
    bus.busy     = (state != IDLE);
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.err_timeout = err_q;

  // Captured byte, grant bookkeeping, start-to-active counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr     <= '0;
      ack_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        tx_data_q  <= bus.req_data[int'(sel)*DATA_W +: DATA_W];
        grant_id_q <= sel;
        rr_ptr     <= (sel == ID_LAST) ? '0 : sel + 1'b1;
      end
      if (state == LAUNCH) begin
        ack_cnt <= '0;
      end else if ((state == WAIT_HI) && !bus.tx_active) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
      if (ack_timeout) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// tb/tb_uart_tx_rr_sched.sv - scoreboard bench for the round-robin uart_tx scheduler
module tb_uart_tx_rr_sched;
  localparam int N_REQ       = 4;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_rr_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_rr_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int              id;
    logic [DATA_W-1:0] data;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t              sbq[$];
  logic [DATA_W-1:0] rq[N_REQ][$];
  logic [DATA_W-1:0] sent_log[$];
  int                mptr = 0;

  int   ua_wait = 0;
  int   ua_len  = 0;
  logic respond = 1'b1;
  logic hold    = 1'b0;
  logic refill  = 1'b0;

  logic last_ts = 1'b0;
  logic s_err   = 1'b0;
  logic s_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int id);
    logic [N_REQ-1:0] v;
    v = '0;
    if (id >= 0) v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic all_empty();
    for (int i = 0; i < N_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid[i] = (rq[i].size() != 0);
      bus.req_data[i*DATA_W +: DATA_W] = (rq[i].size() != 0) ? rq[i][0] : DATA_W'($urandom);
    end
    bus.tx_active = (ua_len > 0) || hold;
  endtask

  // One clock: sample at negedge, run the reference model, apply new inputs just after posedge.
  task automatic cycle();
    logic [N_REQ-1:0] rdy;
    int   id;
    int   r;
    exp_t e;
    @(negedge clk);
    rdy     = bus.req_ready;
    last_ts = bus.tx_start;
    s_err   = bus.err_timeout;
    s_busy  = bus.busy;
    if (rdy != '0) begin
      id = -1;
      for (int k = 0; k < N_REQ; k++)
        if (id < 0 && rq[(mptr + k) % N_REQ].size() != 0) id = (mptr + k) % N_REQ;
      e.id   = id;
      e.data = '0;
      if (id >= 0) begin
        e.data = rq[id].pop_front();
        mptr   = (id + 1) % N_REQ;
      end
      sbq.push_back(e);
    end
    if (ua_len > 0) begin
      ua_len--;
    end else if (ua_wait > 0) begin
      ua_wait--;
      if (ua_wait == 0) ua_len = $urandom_range(3, 12);
    end
    if (last_ts && respond) ua_wait = $urandom_range(2, 10);
    if (refill && $urandom_range(0, 5) == 0) begin
      r = $urandom_range(0, N_REQ - 1);
      if (rq[r].size() < 3) rq[r].push_back(DATA_W'($urandom));
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int limit);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      cycle();
      n++;
      done = all_empty() && !s_busy && ua_len == 0 && ua_wait == 0 && !bus.tx_active && sbq.size() == 0;
    end
    check("drain_done", done, 1);
  endtask

  task automatic wait_ts(input int limit);
    int n;
    n = 0;
    last_ts = 1'b0;
    while (!last_ts && n < limit) begin
      cycle();
      n++;
    end
    check("tx_start_seen", last_ts, 1);
  endtask

  // Monitor: pops the expected grant whenever the DUT launches a byte and checks it is held.
  logic [N_REQ-1:0]  prev_rdy  = '0;
  logic [DATA_W-1:0] cur       = '0;
  logic              cur_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_rdy  = '0;
      cur_valid = 1'b0;
    end else begin
      if (bus.tx_start) begin
        if (sbq.size() == 0) begin
          check("start_without_accept", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("req_ready_onehot", prev_rdy, onehot(e.id));
          check("grant_id", bus.grant_id, e.id);
          check("tx_data", bus.tx_data, e.data);
          cur       = e.data;
          cur_valid = 1'b1;
          sent_log.push_back(bus.tx_data);
        end
      end else if (cur_valid && bus.busy) begin
        check("tx_data_held", bus.tx_data, cur);
      end
      check("ready_legal", ($countones(bus.req_ready) > 1) ||
                           ((bus.req_ready != '0) && (bus.tx_active || bus.busy)), 0);
      prev_rdy = bus.req_ready;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;

    // Round-robin with all four requesters valid
    rq[0].push_back(8'h41); rq[1].push_back(8'h42); rq[2].push_back(8'h43);
    rq[3].push_back(8'h44); rq[0].push_back(8'h41);
    drain(400);
    check("rr_count", sent_log.size(), 5);
    if (sent_log.size() == 5) begin
      check("rr_0", sent_log[0], 8'h41);
      check("rr_1", sent_log[1], 8'h42);
      check("rr_2", sent_log[2], 8'h43);
      check("rr_3", sent_log[3], 8'h44);
      check("rr_4", sent_log[4], 8'h41);
    end

    // Single request
    base = sent_log.size();
    rq[0].push_back(8'h41);
    drain(200);
    check("single_count", sent_log.size(), base + 1);
    check("single_data", sent_log[sent_log.size()-1], 8'h41);
    check("single_busy_idle", s_busy, 0);

    // Pointer wrap: serve requester 2, then 0 and 1 become valid
    base = sent_log.size();
    rq[2].push_back(8'h52);
    wait_ts(50);
    rq[0].push_back(8'h60);
    rq[1].push_back(8'h61);
    drain(300);
    check("wrap_count", sent_log.size(), base + 3);
    if (sent_log.size() == base + 3) begin
      check("wrap_0", sent_log[base], 8'h52);
      check("wrap_1", sent_log[base+1], 8'h60);
      check("wrap_2", sent_log[base+2], 8'h61);
    end

    // uart_tx busy in IDLE blocks grants
    base = sent_log.size();
    hold = 1'b1;
    cycle();
    rq[1].push_back(8'h77);
    repeat (12) cycle();
    check("blocked_no_accept", sbq.size(), 0);
    check("blocked_no_start", sent_log.size(), base);
    hold = 1'b0;
    drain(200);
    check("blocked_then_sent", sent_log[sent_log.size()-1], 8'h77);

    // Timeout when uart_tx never acknowledges
    check("err_before_timeout", s_err, 0);
    respond = 1'b0;
    rq[2].push_back(8'h99);
    wait_ts(50);
    repeat (ACK_TIMEOUT) cycle();
    check("timeout_err_not_yet", s_err, 0);
    check("timeout_busy_not_yet", s_busy, 1);
    cycle();
    check("timeout_err_set", s_err, 1);
    check("timeout_busy_clear", s_busy, 0);
    respond = 1'b1;
    rq[3].push_back(8'hAA);
    drain(200);
    check("after_timeout_sent", sent_log[sent_log.size()-1], 8'hAA);
    check("err_sticky", s_err, 1);

    // Randomized traffic
    refill = 1'b1;
    repeat (2500) cycle();
    refill = 1'b0;
    drain(3000);
    check("err_sticky_random", s_err, 1);

    // Reset in the middle of a frame
    rq[0].push_back(8'h33);
    wait_ts(50);
    begin
      int n;
      n = 0;
      while (!bus.tx_active && n < 30) begin
        cycle();
        n++;
      end
    end
    check("reset_frame_active", bus.tx_active, 1);
    cycle();
    hold = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_req_ready", bus.req_ready, 0);
    check("async_tx_start", bus.tx_start, 0);
    check("async_tx_data", bus.tx_data, 0);
    check("async_grant_id", bus.grant_id, 0);
    check("async_busy", bus.busy, 0);
    check("async_err", bus.err_timeout, 0);
    mptr = 0;
    sbq.delete();
    rq[1].push_back(8'h34);
    rq[3].push_back(8'h35);
    repeat (2) cycle();
    rst_n = 1'b1;
    base = sent_log.size();
    repeat (5) cycle();
    check("post_reset_no_accept", sbq.size(), 0);
    check("post_reset_no_start", sent_log.size(), base);
    hold = 1'b0;
    drain(400);
    check("post_reset_count", sent_log.size(), base + 2);
    if (sent_log.size() == base + 2) begin
      check("post_reset_0", sent_log[base], 8'h34);
      check("post_reset_1", sent_log[base+1], 8'h35);
    end
    check("post_reset_err", s_err, 0);

    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
